// File: rtl/y_demux_pkg.sv
// ---------------------------------------------------------------------------
// y_demux_pkg
// Shared constants and types for the two-lane demultiplexer.
//
// Contents
//   DEPTH        : entries per output lane (the lane logic is built for 2)
//   CNT_W        : width of the per-lane delivery counters
//   CNT_MAX      : saturation value of the delivery counters
//   lane_state_e : lane occupancy state; the encoding equals the number of
//                  buffered words, which the lane relies on for its full flag
//   sat_inc      : saturating increment used by the delivery counters
// ---------------------------------------------------------------------------
package y_demux_pkg;

  localparam int              DEPTH   = 2;
  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } lane_state_e;

  // Counts up by one and sticks at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage : y_demux_pkg

// File: rtl/y_demux_lane.sv
// ---------------------------------------------------------------------------
// y_demux_lane
// One output lane of y_demux2: a 2-entry FIFO with a valid/ready read side,
// a push strobe on the write side and a saturating count of delivered words.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   push_i       : write strobe; already qualified by the parent with
//                  valid & ready & select, ignored while the lane is full
//   push_data_i  : word to write
//   full_o       : lane holds DEPTH words (registered state only)
//   out_valid_o  : lane head is valid
//   out_data_o   : lane head word (oldest entry)
//   out_ready_i  : downstream takes the head this cycle
//   cnt_o        : number of delivered words, saturating at CNT_MAX
//   state_o      : current occupancy state (EMPTY/ONE/FULL) for observation
//
// Handshake: a word moves on a cycle where valid and ready are both high.
// Valid never depends on ready, and head data stays stable while valid is
// high and ready is low.
// ---------------------------------------------------------------------------
module y_demux_lane
  import y_demux_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [SIZE-1:0]  push_data_i,
  output logic             full_o,
  output logic             out_valid_o,
  output logic [SIZE-1:0]  out_data_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [1:0]       state_o
);

  lane_state_e      state_q, state_d;
  logic [SIZE-1:0]  head_q, head_d;   // oldest entry, drives out_data_o
  logic [SIZE-1:0]  tail_q, tail_d;   // second entry, valid only in FULL
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop;

  // A push into a full lane is dropped here as a second line of defence;
  // the parent already withholds ready in that case.
  assign push_ok = push_i & ~full_o;
  assign pop     = out_valid_o & out_ready_i;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (push_ok) state_d = ONE;
      end
      ONE: begin
        // push together with pop keeps one word in the lane
        if (push_ok && !pop)      state_d = FULL;
        else if (!push_ok && pop) state_d = EMPTY;
      end
      FULL: begin
        if (pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    out_valid_o = (state_q != EMPTY);
    // The state encoding is the occupancy, so full is occupancy == DEPTH.
    full_o      = (32'(state_q) == DEPTH);
    out_data_o  = head_q;
    state_o     = state_q;
    cnt_o       = cnt_q;
  end

  // ---------------------------------------------------------------------
  // Storage and delivery counter
  // ---------------------------------------------------------------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push_ok) head_d = push_data_i;
      end
      ONE: begin
        // With a simultaneous pop the pushed word becomes the new head;
        // otherwise it queues behind the current head.
        if (push_ok && pop) head_d = push_data_i;
        else if (push_ok)   tail_d = push_data_i;
      end
      FULL: begin
        if (pop) head_d = tail_q;
      end
      default: begin
        head_d = head_q;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pop) cnt_d = sat_inc(cnt_q);
  end

  // Data registers clear on reset so the head reads 0 until the first push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : y_demux_lane

// File: rtl/y_demux2.sv
// ---------------------------------------------------------------------------
// y_demux2
// Routes each accepted upstream word to one of two independent 2-entry
// output lanes chosen by in_sel. Each lane drains on its own valid/ready
// handshake and counts its deliveries with a saturating 8-bit counter.
//
// Ports
//   clk, reset               : clock (rising edge), synchronous active-high reset
//   in_valid, in_data, in_sel: upstream word and destination lane (0/1)
//   in_ready                 : the word is accepted this cycle if in_valid
//   outN_valid, outN_data    : lane N head
//   outN_ready               : downstream takes lane N head
//   cntN                     : words delivered from lane N (saturating)
//   dbg_state0, dbg_state1   : lane occupancy states (EMPTY/ONE/FULL)
//
// Handshake: every transfer happens on a cycle where valid and ready are
// both high. in_ready depends only on in_sel and registered lane state,
// never on in_valid, and a pop of a full lane does not open in_ready until
// the following cycle, so there is no ready-to-ready combinational path.
// Only DEPTH = 2 is supported.
// ---------------------------------------------------------------------------
module y_demux2
  import y_demux_pkg::*;
#(
  parameter int SIZE  = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [SIZE-1:0]  in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [SIZE-1:0]  out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [SIZE-1:0]  out1_data,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [1:0]       dbg_state0,
  output logic [1:0]       dbg_state1
);

  logic full0, full1;
  logic accept;
  logic push0, push1;

  // Ready reflects the full flag of whichever lane the select points at.
  assign in_ready = in_sel ? ~full1 : ~full0;
  assign accept   = in_valid & in_ready;
  assign push0    = accept & ~in_sel;
  assign push1    = accept &  in_sel;

  y_demux_lane #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_lane0 (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push0),
    .push_data_i (in_data),
    .full_o      (full0),
    .out_valid_o (out0_valid),
    .out_data_o  (out0_data),
    .out_ready_i (out0_ready),
    .cnt_o       (cnt0),
    .state_o     (dbg_state0)
  );

  y_demux_lane #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_lane1 (
    .clk_i       (clk),
    .rst_i       (reset),
    .push_i      (push1),
    .push_data_i (in_data),
    .full_o      (full1),
    .out_valid_o (out1_valid),
    .out_data_o  (out1_data),
    .out_ready_i (out1_ready),
    .cnt_o       (cnt1),
    .state_o     (dbg_state1)
  );

endmodule : y_demux2
